// File: rtl/rpi_sample_shifter_if.sv
// Sample bus and Pi-side serial link of rpi_sample_shifter; the slave modport is the shifter's view.
interface rpi_sample_shifter_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              sample_ready;
  logic              rpi_clk;
  logic              interrupt_enable;
  logic              rpi_data;

  modport master (
    output sample_in, sample_valid, rpi_clk,
    input  sample_ready, interrupt_enable, rpi_data
  );

  modport slave (
    input  sample_in, sample_valid, rpi_clk,
    output sample_ready, interrupt_enable, rpi_data
  );
endinterface

// File: rtl/rpi_sample_shifter.sv
// Buffers I2S samples and shifts them MSB-first to the Pi on falling rpi_clk edges; RPI_SHIFT_PARITY_EN appends an even-parity bit.
// Level updates 1 cycle after a push; sample_ready drops when full, and a word offered while full is dropped and flagged.
module rpi_sample_shifter #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int WATERMARK  = 4
) (
  input  logic                          clk_in,
  input  logic                          reset,
  rpi_sample_shifter_if.slave           bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(DATA_W + 1);
`ifdef RPI_SHIFT_PARITY_EN
  localparam int SH_W = DATA_W + 1;
`else
  localparam int SH_W = DATA_W;
`endif
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(SH_W - 1);
  localparam logic [LVL_W-1:0] WM_LVL   = LVL_W'(WATERMARK);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ARM, SHIFT, DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [LVL_W-1:0]  r_level;
  logic [LVL_W-1:0]  w_level_nxt;
  logic              r_ready;
  logic              r_ovf;
  logic              r_s1;
  logic              r_s2;
  logic              r_s3;
  logic              w_fall;
  logic              w_rise;
  logic [SH_W-1:0]   r_shreg;
  logic [SH_W-1:0]   w_load_val;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] w_head;
  logic              w_push;
  logic              w_pop;
  logic              w_shift;
  logic              w_clr;

  assign w_push = bus.sample_valid && r_ready;
  assign w_head = r_mem[r_rptr];
  assign w_fall = r_s3 && !r_s2;
  assign w_rise = !r_s3 && r_s2;

`ifdef RPI_SHIFT_PARITY_EN
  assign w_load_val = {w_head, ^w_head};
`else
  assign w_load_val = w_head;
`endif

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + LVL_W'(1);
    end else if (!w_push && w_pop) begin
      w_level_nxt = r_level - LVL_W'(1);
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // The counter only advances on falling edges, so reaching LAST_BIT and seeing
  // another fall means the final bit has already been sampled on its rising edge.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_shift     = 1'b0;
    w_clr       = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_level >= WM_LVL) begin
          w_pop       = 1'b1;
          w_state_nxt = ARM;
        end
      end
      ARM: begin
        if (w_rise) begin
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (w_fall) begin
          if (r_cnt != LAST_BIT) begin
            w_shift = 1'b1;
          end else if (r_level != '0) begin
            w_pop = 1'b1;
          end else begin
            w_clr       = 1'b1;
            w_state_nxt = DONE;
          end
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
      r_ready <= 1'b1;
      r_ovf   <= 1'b0;
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else begin
      r_s1 <= bus.rpi_clk;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (w_push) begin
        r_mem[r_wptr] <= bus.sample_in;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (bus.sample_valid && !r_ready) begin
        r_ovf <= 1'b1;
      end
      r_level <= w_level_nxt;
      r_ready <= (w_level_nxt != FULL_LVL);
      if (w_pop) begin
        r_rptr  <= r_rptr + 1'b1;
        r_shreg <= w_load_val;
        r_cnt   <= '0;
      end else if (w_shift) begin
        r_shreg <= r_shreg << 1;
        r_cnt   <= r_cnt + 1'b1;
      end else if (w_clr) begin
        r_shreg <= '0;
      end
    end
  end

  // The serial pin is the top of the shift register, cleared on DONE so it idles low.
  assign bus.rpi_data         = r_shreg[SH_W-1];
  assign bus.interrupt_enable = (r_state == ARM) || (r_state == SHIFT);
  assign bus.sample_ready     = r_ready;
  assign fifo_level           = r_level;
  assign overflow             = r_ovf;
endmodule

// File: tb/tb_rpi_sample_shifter.sv
// Directed bench for rpi_sample_shifter with a divide-by-64 transfer clock generator and a Pi-side capture model.
module tb_rpi_sample_shifter;
`ifdef RPI_SHIFT_PARITY_EN
  localparam int NB = 33;
`else
  localparam int NB = 32;
`endif

  logic       clk_in = 1'b0;
  logic       reset  = 1'b1;
  logic [3:0] fifo_level;
  logic       overflow;
  logic       gen_en = 1'b0;
  int         div = 0;
  int         compared = 0;
  int         mismatched = 0;
  int         cap_bits = 0;
  int         ie_falls = 0;
  logic [63:0]   cap_sr = '0;
  logic [NB-1:0] capq[$];

  rpi_sample_shifter_if #(.DATA_W(32)) bus();

  rpi_sample_shifter #(.DATA_W(32), .FIFO_DEPTH(8), .WATERMARK(4)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .bus        (bus),
    .fifo_level (fifo_level),
    .overflow   (overflow)
  );

  always #10 clk_in = ~clk_in;

  // Interrupt clock generator: rpi_clk toggles every 32 cycles while enabled.
  always @(posedge clk_in) begin
    if (!gen_en || !bus.interrupt_enable) begin
      bus.rpi_clk <= 1'b0;
      div <= 0;
    end else if (div == 31) begin
      bus.rpi_clk <= ~bus.rpi_clk;
      div <= 0;
    end else begin
      div <= div + 1;
    end
  end

  // Pi side: samples rpi_data on every rising rpi_clk edge.
  always @(posedge bus.rpi_clk or posedge reset) begin
    if (reset) begin
      cap_bits = 0;
      cap_sr   = '0;
      capq.delete();
    end else begin
      cap_sr   = {cap_sr[62:0], bus.rpi_data};
      cap_bits = cap_bits + 1;
      if (cap_bits == NB) begin
        capq.push_back(cap_sr[NB-1:0]);
        cap_bits = 0;
      end
    end
  end

  always @(negedge bus.interrupt_enable) ie_falls = ie_falls + 1;

  function automatic logic [NB-1:0] expw(input logic [31:0] w);
`ifdef RPI_SHIFT_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared = compared + 1;
    assert (obs === exp) else begin
      mismatched = mismatched + 1;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk_in);
    #1 reset = 1'b0;
  endtask

  task automatic push(input logic [31:0] w);
    bus.sample_in    = w;
    bus.sample_valid = 1'b1;
    @(posedge clk_in);
    #1 bus.sample_valid = 1'b0;
  endtask

  task automatic wait_words(input string tag, input int n, input int maxc);
    int c = 0;
    while (capq.size() < n && c < maxc) begin
      @(posedge clk_in);
      c++;
    end
    #1 check(tag, 64'(capq.size()), 64'(n));
  endtask

  task automatic wait_ie_low(input string tag, input int maxc);
    int c = 0;
    while (bus.interrupt_enable !== 1'b0 && c < maxc) begin
      @(posedge clk_in);
      c++;
    end
    #1 check(tag, {63'd0, bus.interrupt_enable}, 64'd0);
  endtask

  initial begin
    int f0;
    int c;
    logic [NB-1:0] wq;
    bus.sample_in    = '0;
    bus.sample_valid = 1'b0;

    // Reset state
    do_reset();
    check("rst_ie", {63'd0, bus.interrupt_enable}, 64'd0);
    check("rst_data", {63'd0, bus.rpi_data}, 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_ovf", {63'd0, overflow}, 64'd0);
    check("rst_ready", {63'd0, bus.sample_ready}, 64'd1);

    // Below watermark: no request
    push(32'h0000_0011);
    push(32'h0000_0022);
    push(32'h0000_0033);
    check("bw_level", 64'(fifo_level), 64'd3);
    repeat (5) @(posedge clk_in);
    #1;
    check("bw_ie", {63'd0, bus.interrupt_enable}, 64'd0);
    check("bw_ready", {63'd0, bus.sample_ready}, 64'd1);
    check("bw_level2", 64'(fifo_level), 64'd3);

    // Four-word transfer
    do_reset();
    gen_en = 1'b1;
    push(32'hA5A5_0001);
    push(32'hA5A5_0002);
    push(32'hA5A5_0003);
    push(32'hA5A5_0004);
    check("xf_level4", 64'(fifo_level), 64'd4);
    check("xf_ie_pre", {63'd0, bus.interrupt_enable}, 64'd0);
    @(posedge clk_in);
    #1;
    check("xf_ie_rise", {63'd0, bus.interrupt_enable}, 64'd1);
    check("xf_level3", 64'(fifo_level), 64'd3);
    wait_words("xf_words", 4, 4 * 2048 + 400);
    for (int i = 0; i < 4 && i < capq.size(); i++) begin
      check($sformatf("xf_word%0d", i), 64'(capq[i]), 64'(expw(32'hA5A5_0001 + 32'(i))));
    end
    wait_ie_low("xf_ie_fall", 200);
    check("xf_level0", 64'(fifo_level), 64'd0);
    check("xf_data0", {63'd0, bus.rpi_data}, 64'd0);
    check("xf_ovf", {63'd0, overflow}, 64'd0);

    // Word pushed mid-burst joins the burst
    do_reset();
    f0 = ie_falls;
    push(32'hB000_0000);
    push(32'hB000_0001);
    push(32'hB000_0002);
    push(32'hB000_0003);
    wait_words("bu_first", 1, 2048 + 400);
    push(32'h1234_5678);
    wait_words("bu_words", 5, 5 * 2048 + 400);
    check("bu_no_drop", 64'(ie_falls - f0), 64'd0);
    for (int i = 0; i < 4 && i < capq.size(); i++) begin
      check($sformatf("bu_word%0d", i), 64'(capq[i]), 64'(expw(32'hB000_0000 + 32'(i))));
    end
    if (capq.size() >= 5) check("bu_word4", 64'(capq[4]), 64'(expw(32'h1234_5678)));
    wait_ie_low("bu_ie_fall", 200);
    check("bu_one_fall", 64'(ie_falls - f0), 64'd1);

    // Overflow with the transfer clock held off
    do_reset();
    gen_en = 1'b0;
    for (int i = 0; i < 11; i++) begin
      bus.sample_in    = 32'hC0DE_0000 + 32'(i);
      bus.sample_valid = 1'b1;
      @(posedge clk_in);
      #1;
    end
    bus.sample_valid = 1'b0;
    check("ov_ready", {63'd0, bus.sample_ready}, 64'd0);
    check("ov_flag", {63'd0, overflow}, 64'd1);
    check("ov_level", 64'(fifo_level), 64'd8);
    check("ov_ie", {63'd0, bus.interrupt_enable}, 64'd1);
    gen_en = 1'b1;
    wait_words("ov_words", 9, 9 * 2048 + 400);
    for (int i = 0; i < 9 && i < capq.size(); i++) begin
      check($sformatf("ov_word%0d", i), 64'(capq[i]), 64'(expw(32'hC0DE_0000 + 32'(i))));
    end
    wait_ie_low("ov_ie_fall", 200);
    check("ov_level0", 64'(fifo_level), 64'd0);
    check("ov_sticky", {63'd0, overflow}, 64'd1);

    // Reset mid-word at bit 17 (overflow still set from above)
    push(32'hD000_0001);
    push(32'hD000_0002);
    push(32'hD000_0003);
    push(32'hD000_0004);
    c = 0;
    while (cap_bits < 17 && c < 2048) begin
      @(posedge clk_in);
      c++;
    end
    #1 check("mr_bit17", 64'(cap_bits), 64'd17);
    reset = 1'b1;
    @(posedge clk_in);
    #1 reset = 1'b0;
    check("mr_ie", {63'd0, bus.interrupt_enable}, 64'd0);
    check("mr_data", {63'd0, bus.rpi_data}, 64'd0);
    check("mr_level", 64'(fifo_level), 64'd0);
    check("mr_ovf", {63'd0, overflow}, 64'd0);
    check("mr_ready", {63'd0, bus.sample_ready}, 64'd1);
    repeat (200) @(posedge clk_in);
    #1;
    check("mr_idle_ie", {63'd0, bus.interrupt_enable}, 64'd0);
    check("mr_no_words", 64'(capq.size()), 64'd0);

`ifdef RPI_SHIFT_PARITY_EN
    // Parity bit follows the LSB
    do_reset();
    push(32'h0000_0007);
    push(32'h0000_0001);
    push(32'h0000_0003);
    push(32'h8000_0000);
    wait_words("pa_words", 4, 4 * 2048 + 400);
    if (capq.size() >= 4) begin
      wq = capq[0];
      check("pa_word0", 64'(wq), 64'h0_0000_000F);
      check("pa_bit0", {63'd0, wq[0]}, 64'd1);
      wq = capq[1];
      check("pa_word1", 64'(wq), 64'h0_0000_0003);
      wq = capq[2];
      check("pa_word2", 64'(wq), 64'h0_0000_0006);
      wq = capq[3];
      check("pa_word3", 64'(wq), 64'h1_0000_0001);
    end
    wait_ie_low("pa_ie_fall", 200);
`else
    wq = '0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
